kbd_ps2_buffer: RTL and testbench



---
 rtl/kbd_ps2_buffer_if.sv | 22 ++
 rtl/kbd_ps2_buffer.sv | 174 +++++++++++++++++
 tb/tb_kbd_ps2_buffer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_ps2_buffer_if.sv
// Memory-mapped keyboard window between the manager (master) and the PS/2 byte buffer (slave).
// The buffer does not apply backpressure: software polls kbd_buflen and reads kbd_char combinationally.
interface kbd_ps2_buffer_if;
   logic [7:0] kbd_en;
   logic [7:0] kbd_ra;
   logic [7:0] kbd_buflen;
   logic [7:0] kbd_char;

   modport master (
      output kbd_en,
      output kbd_ra,
      input  kbd_buflen,
      input  kbd_char
   );

   modport slave (
      input  kbd_en,
      input  kbd_ra,
      output kbd_buflen,
      output kbd_char
   );
endinterface

// File: rtl/kbd_ps2_buffer.sv
// PS/2 set-2 receiver feeding a linear make-code buffer; a byte lands SYNC_STAGES+2 clocks after its stop-bit edge.
// There is no backpressure: bytes arriving while the buffer is full or capture is disabled are dropped.
module kbd_ps2_buffer #(
   parameter int DEPTH       = 240,
   parameter int TIMEOUT     = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   kbd_ps2_buffer_if.slave  kbd,
   output logic             frame_err
);
   localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int             TW        = $clog2(TIMEOUT + 1);
   localparam logic [7:0]     DEPTH_B   = 8'(DEPTH);
   localparam logic [TW-1:0]  TIMEOUT_C = TW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_prev;
   logic                   clk_s;
   logic                   dat_s;
   logic                   fall;
   logic [TW-1:0]          idle_cnt;
   logic                   timeout_hit;

   rx_state_t              state, state_nxt;
   logic [2:0]             bit_cnt, cnt_nxt;
   logic [7:0]             shreg, shreg_nxt;
   logic                   par_bit, par_nxt;
   logic                   err_set;
   logic                   stb_set;
   logic                   byte_stb;

   logic                   brk;
   logic                   ext;
   logic                   en1_prev;
   logic                   clr;
   logic                   is_prefix;
   logic                   store;
   logic [7:0]             buflen;
   logic [7:0]             mem [DEPTH];
   logic                   unused_bits;

   assign clk_s       = clk_sync[SYNC_STAGES-1];
   assign dat_s       = dat_sync[SYNC_STAGES-1];
   assign fall        = clk_prev & ~clk_s;
   assign timeout_hit = (state != IDLE) && (idle_cnt == TIMEOUT_C);

   // Synchronisers idle high so a reset release never looks like a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
         idle_cnt <= '0;
      end else begin
         clk_sync <= SYNC_STAGES'({clk_sync, ps2_clk});
         dat_sync <= SYNC_STAGES'({dat_sync, ps2_data});
         clk_prev <= clk_s;
         if (fall)
            idle_cnt <= '0;
         else if (idle_cnt != TIMEOUT_C)
            idle_cnt <= idle_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         byte_stb  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= cnt_nxt;
         shreg     <= shreg_nxt;
         par_bit   <= par_nxt;
         byte_stb  <= stb_set;
         frame_err <= err_set;
      end
   end

   // Timeout takes priority over a coincident edge so a stalled frame is always abandoned.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = bit_cnt;
      shreg_nxt = shreg;
      par_nxt   = par_bit;
      err_set   = 1'b0;
      stb_set   = 1'b0;
      if (timeout_hit) begin
         state_nxt = IDLE;
         err_set   = 1'b1;
      end else if (fall) begin
         case (state)
            IDLE: begin
               if (!dat_s) begin
                  state_nxt = DATA;
                  cnt_nxt   = 3'd0;
               end else begin
                  err_set = 1'b1;
               end
            end
            DATA: begin
               shreg_nxt = {dat_s, shreg[7:1]};
               cnt_nxt   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state_nxt = PARITY;
            end
            PARITY: begin
               par_nxt   = dat_s;
               state_nxt = STOP;
            end
            STOP: begin
               state_nxt = IDLE;
               if (dat_s && ((^shreg) ^ par_bit))
                  stb_set = 1'b1;
               else
                  err_set = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // shreg is untouched until the next frame's first data bit, so it still holds the byte during byte_stb.
   assign is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);
   assign clr       = kbd.kbd_en[1] & ~en1_prev;
   assign store     = byte_stb && !is_prefix && !brk && kbd.kbd_en[0]
                      && (buflen < DEPTH_B) && !clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         brk      <= 1'b0;
         ext      <= 1'b0;
         en1_prev <= 1'b0;
         buflen   <= '0;
      end else begin
         en1_prev <= kbd.kbd_en[1];
         if (byte_stb) begin
            if (shreg == 8'hE0) begin
               ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               brk <= 1'b0;
               ext <= 1'b0;
            end
         end
         if (clr)
            buflen <= '0;
         else if (store)
            buflen <= buflen + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (store)
         mem[buflen[AW-1:0]] <= shreg;
   end

   assign kbd.kbd_buflen = buflen;
   assign kbd.kbd_char   = (kbd.kbd_ra < buflen) ? mem[kbd.kbd_ra[AW-1:0]] : 8'h00;

   // The extend flag only tracks prefix state; released keys are discarded via brk alone.
   assign unused_bits = ^{kbd.kbd_en[7:2], ext};
endmodule

// File: tb/tb_kbd_ps2_buffer.sv
// Scoreboarded bench for kbd_ps2_buffer: a queue-based keyboard model predicts buflen steps and frame errors,
// a negedge monitor consumes them as the DUT produces them.
module tb_kbd_ps2_buffer;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 200;
   localparam int H       = 6;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic ps2_clk  = 1'b1;
   logic ps2_data = 1'b1;
   logic frame_err;

   kbd_ps2_buffer_if kbd_if();

   kbd_ps2_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .kbd      (kbd_if.slave),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   byte unsigned m_buf[$];
   bit           m_brk = 1'b0;
   bit           m_ext = 1'b0;
   bit           m_en  = 1'b0;
   int           exp_len_q[$];
   int           err_q[$];
   int           frame_no = 0;
   int           last_len = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Keyboard model: a queue of stored make codes plus break/extend flags.
   function automatic void m_clear();
      if (m_buf.size() > 0) begin
         m_buf.delete();
         exp_len_q.push_back(0);
      end
   endfunction

   function automatic void m_byte(input byte unsigned b, input bit clr_same);
      if (clr_same) m_clear();
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (m_brk) begin
         m_brk = 1'b0;
         m_ext = 1'b0;
      end else begin
         m_ext = 1'b0;
         if (!clr_same && m_en && m_buf.size() < DEPTH) begin
            m_buf.push_back(b);
            exp_len_q.push_back(m_buf.size());
         end
      end
   endfunction

   task automatic ps2_bit(input bit b);
      ps2_data = b;
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b1;
   endtask

   // collide: raise kbd_en[1] on exactly the cycle the DUT strobes this byte.
   task automatic send_frame(input byte unsigned b, input bit bad_par = 1'b0,
                             input bit stop = 1'b1, input bit collide = 1'b0);
      bit p;
      p = ~(^b) ^ bad_par;
      frame_no++;
      if (bad_par || !stop) err_q.push_back(frame_no);
      else m_byte(b, collide);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(p);
      ps2_data = stop;
      repeat (H) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (collide) begin
         repeat (3) @(posedge clk);
         #1 kbd_if.kbd_en = 8'h03;
         repeat (H - 3) @(posedge clk);
      end else begin
         repeat (H) @(posedge clk);
      end
      #1 ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic send_partial(input int n);
      ps2_bit(1'b0);
      for (int i = 0; i < n; i++) ps2_bit(1'($urandom));
      ps2_data = 1'b1;
   endtask

   task automatic set_en(input logic [7:0] v);
      @(posedge clk);
      #1 kbd_if.kbd_en = v;
      m_en = v[0];
      repeat (2) @(posedge clk);
   endtask

   task automatic clear_pulse();
      m_clear();
      @(posedge clk);
      #1 kbd_if.kbd_en = {6'b0, 1'b1, m_en};
      @(posedge clk);
      #1 kbd_if.kbd_en = {7'b0, m_en};
      repeat (2) @(posedge clk);
   endtask

   task automatic check_buf(input string tag);
      chk($sformatf("%s_buflen", tag), int'(kbd_if.kbd_buflen), m_buf.size());
      for (int ra = 0; ra < 8; ra++) begin
         kbd_if.kbd_ra = 8'(ra);
         #1;
         chk($sformatf("%s_char_ra%0d", tag, ra), int'(kbd_if.kbd_char),
             (ra < m_buf.size()) ? int'(m_buf[ra]) : 0);
      end
      kbd_if.kbd_ra = 8'd200;
      #1;
      chk($sformatf("%s_char_ra200", tag), int'(kbd_if.kbd_char), 0);
      kbd_if.kbd_ra = 8'd0;
   endtask

   // Monitor: every frame_err pulse and every buflen step must match a pending prediction.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_len = int'(kbd_if.kbd_buflen);
      end else begin
         if (frame_err) begin
            chk("frame_err_predicted", int'(err_q.size() > 0), 1);
            if (err_q.size() > 0) void'(err_q.pop_front());
         end
         if (int'(kbd_if.kbd_buflen) != last_len) begin
            if (exp_len_q.size() == 0)
               chk("buflen_unpredicted_step", int'(kbd_if.kbd_buflen), last_len);
            else
               chk("buflen_step", int'(kbd_if.kbd_buflen), exp_len_q.pop_front());
            last_len = int'(kbd_if.kbd_buflen);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      kbd_if.kbd_en = 8'h00;
      kbd_if.kbd_ra = 8'h00;
      #12;
      chk("reset_buflen", int'(kbd_if.kbd_buflen), 0);
      chk("reset_frame_err", int'(frame_err), 0);
      chk("reset_char", int'(kbd_if.kbd_char), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);

      set_en(8'h01);
      send_frame(8'h1C);
      check_buf("make");

      clear_pulse();
      send_frame(8'h1C); send_frame(8'hF0); send_frame(8'h1C); send_frame(8'hE0);
      send_frame(8'h75); send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
      check_buf("filter");

      send_frame(8'h1C, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b0);
      frame_no++; err_q.push_back(frame_no);
      ps2_bit(1'b1);
      frame_no++; err_q.push_back(frame_no);
      send_partial(5);
      repeat (TIMEOUT + 10) @(posedge clk);
      send_frame(8'h32);
      check_buf("errors");

      clear_pulse();
      foreach (m_buf[i]) ;
      send_frame(8'h15); send_frame(8'h1D); send_frame(8'h24);
      send_frame(8'h2D); send_frame(8'h2C); send_frame(8'h35);
      check_buf("full");

      clear_pulse();
      set_en(8'h00);
      send_frame(8'h1C);
      check_buf("disabled");

      set_en(8'h01);
      send_frame(8'h1C);
      send_frame(8'h2B, 1'b0, 1'b1, 1'b1);
      check_buf("collide");
      send_frame(8'h1C);
      check_buf("hold_clear");
      set_en(8'h01);
      m_clear();
      set_en(8'h03);
      set_en(8'h01);
      check_buf("reclear");

      send_frame(8'h1C);
      send_frame(8'h33);
      send_partial(4);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      m_buf.delete();
      m_brk = 1'b0;
      m_ext = 1'b0;
      #1;
      chk("async_reset_buflen", int'(kbd_if.kbd_buflen), 0);
      chk("async_reset_frame_err", int'(frame_err), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      send_frame(8'h29);
      check_buf("after_reset");

      for (int n = 0; n < 60; n++) begin
         int kind;
         kind = $urandom_range(0, 11);
         case (kind)
            0:       send_frame(8'($urandom_range(1, 8'hDF)), 1'b1);
            1:       send_frame(8'($urandom_range(1, 8'hDF)), 1'b0, 1'b0);
            2, 3:    send_frame(8'hE0);
            4, 5:    send_frame(8'hF0);
            6:       clear_pulse();
            7:       set_en({7'b0, ~m_en});
            default: send_frame(8'($urandom_range(1, 8'hDF)));
         endcase
         if (n % 10 == 9) check_buf($sformatf("rand%0d", n));
      end

      repeat (20) @(posedge clk);
      chk("err_queue_drained", err_q.size(), 0);
      chk("len_queue_drained", exp_len_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
